// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and constants for the memory-access stage.
//   mem_op_t    - memory operation requested by the decoder (3 bits)
//   mem_state_t - handshake state of mem_stage
//   WSTRB_ALL   - byte-enable pattern for a full-word store
//   decode_op   - maps a raw 3-bit op field onto mem_op_t; unknown codes become MEM_NONE
//   is_store_op - true for SW/SB
package mem_stage_pkg;

  typedef enum logic [2:0] {
    MEM_NONE = 3'd0,
    MEM_LW   = 3'd1,
    MEM_LBU  = 3'd2,
    MEM_SW   = 3'd3,
    MEM_SB   = 3'd4
  } mem_op_t;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_REQ  = 2'd1,
    MS_RESP = 2'd2
  } mem_state_t;

  localparam logic [3:0] WSTRB_ALL = 4'b1111;

  // Codes 5..7 are not operations; they fall back to plain pass-through.
  function automatic mem_op_t decode_op(input logic [2:0] raw);
    case (raw)
      3'd1:    return MEM_LW;
      3'd2:    return MEM_LBU;
      3'd3:    return MEM_SW;
      3'd4:    return MEM_SB;
      default: return MEM_NONE;
    endcase
  endfunction

  function automatic logic is_store_op(input mem_op_t o);
    return (o == MEM_SW) || (o == MEM_SB);
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: combinational load data formatter for the memory stage.
// Ports:
//   offset - byte offset of the access within the word (alu_result[1:0])
//   op     - mem_op_t of the access
//   rdata  - raw word returned by data memory
//   data   - write-back value (LW: whole word, LBU: zero-extended byte, others: 0)
module load_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [2:0]  op,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  always_comb begin
    data = '0;
    case (op)
      MEM_LW:  data = rdata;
      // Little-endian: offset 0 selects bits 7:0, offset 3 selects bits 31:24.
      MEM_LBU: data = {24'b0, rdata[{offset, 3'b000} +: 8]};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage behind the integer ALU.
// Uses the ALU result as the effective address for lw/lbu/sw/sb and performs one
// data-memory transaction over a request (valid/ready) + response handshake.
// Non-memory ops pass the ALU result straight to write-back.
//
// Ports:
//   clk, rstn        - clock, synchronous active-low reset
//   enabled          - start strobe, only looked at in IDLE
//   op               - mem_op_t code (unknown codes act as NONE)
//   alu_result       - address for memory ops, value for NONE
//   store_data       - rs2 value for stores
//   mem_req_valid/mem_req_ready, mem_we, mem_wstrb, mem_addr, mem_wdata - request channel
//   mem_resp_valid, mem_rdata - response channel (read data / write ack)
//   completed        - one-cycle done pulse
//   result           - write-back value, held until the next completion
//   bus_error        - pulses with completed on watchdog expiry or misaligned access
//
// Parameters:
//   ADDR_WIDTH - low address bits driven on mem_addr
//   WAIT_LIMIT - cycles allowed in REQ or in RESP before a bus error; 0 disables
//
// Build option:
//   MEM_STAGE_MISALIGN_CHECK_EN - when defined, LW/SW with a nonzero byte offset
//   complete immediately with bus_error and the faulting address as result.
//   Otherwise they access the enclosing aligned word.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int WAIT_LIMIT = 255
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enabled,
  input  logic [2:0]            op,
  input  logic [31:0]           alu_result,
  input  logic [31:0]           store_data,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_we,
  output logic [3:0]            mem_wstrb,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_resp_valid,
  input  logic [31:0]           mem_rdata,
  output logic                  completed,
  output logic [31:0]           result,
  output logic                  bus_error
);

  // The counter never needs to hold WAIT_LIMIT itself: the abort happens on the
  // cycle it would get there, so WAIT_LIMIT-1 is the largest stored value.
  localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [CW-1:0] LIMIT_M1 = CW'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);
  localparam bit WDOG_EN = (WAIT_LIMIT > 0);

  mem_state_t state_q, state_d;
  mem_op_t    op_q, op_d;
  mem_op_t    req_op;
  logic [1:0] offset_q, offset_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic       wdog_hit;

  logic                  req_valid_d;
  logic                  we_d;
  logic [3:0]            wstrb_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [31:0]           wdata_d;
  logic                  completed_d;
  logic                  bus_error_d;
  logic [31:0]           result_d;
  logic [31:0]           load_data;

  assign req_op   = decode_op(op);
  assign wdog_hit = WDOG_EN && (wait_cnt_q == LIMIT_M1);

  load_align u_load_align (
    .offset (offset_q),
    .op     (op_q),
    .rdata  (mem_rdata),
    .data   (load_data)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= MS_IDLE;
      op_q          <= MEM_NONE;
      offset_q      <= '0;
      wait_cnt_q    <= '0;
      mem_req_valid <= 1'b0;
      mem_we        <= 1'b0;
      mem_wstrb     <= '0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      completed     <= 1'b0;
      bus_error     <= 1'b0;
      result        <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      offset_q      <= offset_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_req_valid <= req_valid_d;
      mem_we        <= we_d;
      mem_wstrb     <= wstrb_d;
      mem_addr      <= addr_d;
      mem_wdata     <= wdata_d;
      completed     <= completed_d;
      bus_error     <= bus_error_d;
      result        <= result_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    offset_d    = offset_q;
    wait_cnt_d  = wait_cnt_q;
    req_valid_d = mem_req_valid;
    we_d        = mem_we;
    wstrb_d     = mem_wstrb;
    addr_d      = mem_addr;
    wdata_d     = mem_wdata;
    completed_d = 1'b0;
    bus_error_d = 1'b0;
    result_d    = result;

    case (state_q)
      MS_IDLE: begin
        if (enabled) begin
          if (req_op == MEM_NONE) begin
            completed_d = 1'b1;
            result_d    = alu_result;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
          end else if ((req_op == MEM_LW || req_op == MEM_SW) && (alu_result[1:0] != 2'b00)) begin
            completed_d = 1'b1;
            bus_error_d = 1'b1;
            result_d    = alu_result;
`endif
          end else begin
            state_d     = MS_REQ;
            op_d        = req_op;
            offset_d    = alu_result[1:0];
            wait_cnt_d  = '0;
            req_valid_d = 1'b1;
            addr_d      = {alu_result[ADDR_WIDTH-1:2], 2'b00};
            we_d        = is_store_op(req_op);
            case (req_op)
              MEM_SW: begin
                wstrb_d = WSTRB_ALL;
                wdata_d = store_data;
              end
              MEM_SB: begin
                wstrb_d = 4'b0001 << alu_result[1:0];
                wdata_d = {4{store_data[7:0]}};
              end
              default: begin
                wstrb_d = '0;
                wdata_d = '0;
              end
            endcase
          end
        end
      end

      // A response arriving together with ready is deliberately not looked at here.
      MS_REQ: begin
        if (mem_req_ready) begin
          state_d     = MS_RESP;
          req_valid_d = 1'b0;
          wait_cnt_d  = '0;
        end else if (wdog_hit) begin
          state_d     = MS_IDLE;
          req_valid_d = 1'b0;
          completed_d = 1'b1;
          bus_error_d = 1'b1;
          result_d    = '0;
        end else if (WDOG_EN) begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end

      MS_RESP: begin
        if (mem_resp_valid) begin
          state_d     = MS_IDLE;
          completed_d = 1'b1;
          if (op_q == MEM_LW || op_q == MEM_LBU) begin
            result_d = load_data;
          end
        end else if (wdog_hit) begin
          state_d     = MS_IDLE;
          completed_d = 1'b1;
          bus_error_d = 1'b1;
          result_d    = '0;
        end else if (WDOG_EN) begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end

      default: begin
        state_d     = MS_IDLE;
        req_valid_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage (WAIT_LIMIT set to 8).
// A small memory responder answers requests after chosen delays; expected
// latency, result, bus_error and request fields come from a transaction-level
// model of the stage's rules. Honours MEM_STAGE_MISALIGN_CHECK_EN.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int WL     = 8;
  localparam int BUDGET = 64;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
  localparam bit MISALIGN_EN = 1'b1;
`else
  localparam bit MISALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enabled = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] alu_result = '0;
  logic [31:0] store_data = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        completed;
  logic [31:0] result;
  logic        bus_error;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] model_result = '0;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_WIDTH(32), .WAIT_LIMIT(WL)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .enabled        (enabled),
    .op             (op),
    .alu_result     (alu_result),
    .store_data     (store_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_we         (mem_we),
    .mem_wstrb      (mem_wstrb),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata),
    .completed      (completed),
    .result         (result),
    .bus_error      (bus_error)
  );

  // One instruction through the stage. rd = cycles ready is held low while
  // valid is up, sd = idle cycles before the response after acceptance.
  task automatic run_op(input string name, input logic [2:0] op_in, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [31:0] rdata,
                        input int rd, input int sd, input bit early, input bit busy_en);
    bit is_lw, is_lbu, is_sw, is_sb, is_mem, is_st, misal;
    int off, exp_lat, exp_valid, got_lat, valid_cnt, req_seen, resp_seen, bad_fields;
    bit accepted;
    logic [31:0] exp_res, exp_addr, exp_wdata, first_addr;
    logic [3:0]  exp_wstrb, first_wstrb;
    logic        exp_err;

    is_lw  = (op_in == MEM_LW);
    is_lbu = (op_in == MEM_LBU);
    is_sw  = (op_in == MEM_SW);
    is_sb  = (op_in == MEM_SB);
    is_st  = is_sw || is_sb;
    is_mem = is_lw || is_lbu || is_st;
    off    = int'(addr & 32'd3);
    misal  = MISALIGN_EN && (is_lw || is_sw) && (off != 0);
    exp_addr  = addr & 32'hFFFF_FFFC;
    exp_wstrb = is_sw ? 4'hF : (is_sb ? 4'(1 << off) : 4'h0);
    exp_wdata = is_sw ? sdata : (is_sb ? {4{sdata[7:0]}} : 32'h0);
    exp_err   = 1'b0;
    if (!is_mem) begin
      exp_lat = 1; exp_valid = 0; exp_res = addr;
    end else if (misal) begin
      exp_lat = 1; exp_valid = 0; exp_res = addr; exp_err = 1'b1;
    end else if (rd >= WL) begin
      exp_lat = 1 + WL; exp_valid = WL; exp_res = 32'h0; exp_err = 1'b1;
    end else if (sd >= WL) begin
      exp_lat = 1 + (rd + 1) + WL; exp_valid = rd + 1; exp_res = 32'h0; exp_err = 1'b1;
    end else begin
      exp_lat = 3 + rd + sd; exp_valid = rd + 1;
      if (is_lw)       exp_res = rdata;
      else if (is_lbu) exp_res = (rdata >> (8 * off)) & 32'hFF;
      else             exp_res = model_result;
    end

    @(negedge clk);
    enabled = 1'b1; op = op_in; alu_result = addr; store_data = sdata;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    got_lat = -1; valid_cnt = 0; req_seen = 0; resp_seen = 0; bad_fields = 0;
    accepted = 1'b0; first_addr = '0; first_wstrb = '0;
    for (int cyc = 1; cyc <= BUDGET; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (!busy_en) enabled = 1'b0;
      if (completed === 1'b1) begin
        got_lat = cyc;
        break;
      end
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = $urandom;
      if (mem_req_valid === 1'b1) begin
        valid_cnt++; req_seen++;
        if (valid_cnt == 1) begin first_addr = mem_addr; first_wstrb = mem_wstrb; end
        if (mem_addr !== exp_addr || mem_we !== is_st || mem_wstrb !== exp_wstrb ||
            (is_st && mem_wdata !== exp_wdata)) bad_fields++;
        if (req_seen > rd) begin
          mem_req_ready = 1'b1; accepted = 1'b1;
          if (early) begin mem_resp_valid = 1'b1; mem_rdata = ~rdata; end
        end
      end else if (accepted) begin
        resp_seen++;
        if (resp_seen > sd) begin mem_resp_valid = 1'b1; mem_rdata = rdata; end
      end
    end
    enabled = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;

    n_checks++;
    if (got_lat !== exp_lat)
      $display("[TB] FAIL %s latency: got %0d expected %0d (-1 = no completion)", name, got_lat, exp_lat);
    else n_pass++;
    n_checks++;
    if (valid_cnt !== exp_valid)
      $display("[TB] FAIL %s valid_cycles: got %0d expected %0d", name, valid_cnt, exp_valid);
    else n_pass++;
    if (got_lat > 0) begin
      n_checks++;
      if (result !== exp_res)
        $display("[TB] FAIL %s result: got %h expected %h", name, result, exp_res);
      else n_pass++;
      n_checks++;
      if (bus_error !== exp_err)
        $display("[TB] FAIL %s bus_error: got %b expected %b", name, bus_error, exp_err);
      else n_pass++;
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (completed !== 1'b0 || bus_error !== 1'b0)
        $display("[TB] FAIL %s pulse_width: completed=%b bus_error=%b expected 0 0", name, completed, bus_error);
      else n_pass++;
    end
    if (exp_valid > 0 && valid_cnt > 0) begin
      n_checks++;
      if (first_addr !== exp_addr || first_wstrb !== exp_wstrb)
        $display("[TB] FAIL %s req_addr_wstrb: got %h/%b expected %h/%b", name, first_addr, first_wstrb, exp_addr, exp_wstrb);
      else n_pass++;
      n_checks++;
      if (bad_fields !== 0)
        $display("[TB] FAIL %s req_fields_stable: got %0d bad cycles expected 0", name, bad_fields);
      else n_pass++;
    end
    model_result = exp_res;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({completed, bus_error, mem_req_valid, mem_we} !== 4'b0)
      $display("[TB] FAIL reset_ctrl: got %b expected 0000", {completed, bus_error, mem_req_valid, mem_we});
    else n_pass++;
    n_checks++;
    if (mem_wstrb !== 4'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0)
      $display("[TB] FAIL reset_bus: got %b %h %h expected zeros", mem_wstrb, mem_addr, mem_wdata);
    else n_pass++;
    n_checks++;
    if (result !== 32'h0)
      $display("[TB] FAIL reset_result: got %h expected 0", result);
    else n_pass++;
    rstn = 1'b1;
    model_result = '0;
  endtask

  task automatic test_passthrough();
    run_op("none", MEM_NONE, 32'hDEADBEEF, 32'h0, 32'h0, 0, 0, 1'b0, 1'b0);
    run_op("bad_op", 3'd6, 32'h0BADC0DE, 32'h1, 32'h2, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_loads();
    run_op("lw", MEM_LW, 32'h100, 32'h0, 32'h12345678, 0, 0, 1'b0, 1'b0);
    run_op("lbu3", MEM_LBU, 32'h103, 32'h0, 32'hA1B2C3D4, 0, 0, 1'b0, 1'b0);
    run_op("lbu1", MEM_LBU, 32'h101, 32'h0, 32'hA1B2C3D4, 0, 0, 1'b0, 1'b0);
    run_op("lw_early", MEM_LW, 32'h180, 32'h0, 32'h0F0F1234, 0, 1, 1'b1, 1'b1);
  endtask

  task automatic test_stores();
    run_op("sb_wait", MEM_SB, 32'h202, 32'h000000EE, 32'h0, 4, 0, 1'b0, 1'b0);
    run_op("sw", MEM_SW, 32'h204, 32'hCAFEF00D, 32'h0, 1, 2, 1'b0, 1'b1);
  endtask

  task automatic test_watchdog();
    run_op("wd_req", MEM_LW, 32'h500, 32'h0, 32'h11, 1000, 0, 1'b0, 1'b0);
    run_op("after_wd", MEM_NONE, 32'h13572468, 32'h0, 32'h0, 0, 0, 1'b0, 1'b0);
    run_op("req_edge_ok", MEM_LW, 32'h504, 32'h0, 32'h55AA55AA, WL - 1, 0, 1'b0, 1'b0);
    run_op("req_edge_err", MEM_SW, 32'h508, 32'h1, 32'h0, WL, 0, 1'b0, 1'b0);
    run_op("resp_edge_ok", MEM_LBU, 32'h50E, 32'h0, 32'h00C30000, 0, WL - 1, 1'b0, 1'b0);
    run_op("resp_edge_err", MEM_LW, 32'h510, 32'h0, 32'h77, 2, WL, 1'b0, 1'b0);
  endtask

  task automatic test_misalign();
    run_op("sw_mis", MEM_SW, 32'h301, 32'h89ABCDEF, 32'h0, 0, 0, 1'b0, 1'b0);
    run_op("lw_mis", MEM_LW, 32'h302, 32'h0, 32'hFEEDFACE, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int late;
    @(negedge clk);
    enabled = 1'b1; op = MEM_LW; alu_result = 32'h400;
    @(posedge clk);
    @(negedge clk);
    enabled = 1'b0; mem_req_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_req_ready = 1'b0;
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    n_checks++;
    if ({completed, bus_error, mem_req_valid, mem_we} !== 4'b0 || result !== 32'h0 ||
        mem_wstrb !== 4'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0)
      $display("[TB] FAIL reset_mid_outputs: got %b %b %h %h %h expected all zero",
               {completed, bus_error, mem_req_valid, mem_we}, mem_wstrb, mem_addr, mem_wdata, result);
    else n_pass++;
    late = 0;
    mem_resp_valid = 1'b1; mem_rdata = 32'h99999999;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      if (completed === 1'b1) late++;
    end
    mem_resp_valid = 1'b0;
    n_checks++;
    if (late !== 0)
      $display("[TB] FAIL late_resp: got %0d completions expected 0", late);
    else n_pass++;
    model_result = '0;
    run_op("after_rst", MEM_NONE, 32'h24681357, 32'h0, 32'h0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back(input int n);
    logic [2:0] o;
    int rd, sd;
    for (int i = 0; i < n; i++) begin
      o  = 3'($urandom_range(0, 7));
      rd = ($urandom_range(0, 7) == 0) ? WL + int'($urandom_range(0, 2)) : int'($urandom_range(0, 3));
      sd = ($urandom_range(0, 7) == 0) ? WL + int'($urandom_range(0, 2)) : int'($urandom_range(0, 3));
      run_op("rand", o, $urandom, $urandom, $urandom, rd, sd,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    $display("[TB] mem_stage bench start, misalign check %0d", MISALIGN_EN);
    test_reset();
    test_passthrough();
    test_loads();
    test_stores();
    test_watchdog();
    test_misalign();
    test_reset_mid();
    test_back_to_back(40);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
